// File: rtl/main_mem_responder.sv
// Main-memory model answering L2 line reads and write-backs after a fixed LATENCY,
// with per-line valid bits, combined write-then-read transactions and abort detection.
module main_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_L2_MEM,
  input  logic         write_L2_MEM,
  input  logic [7:0]   index_L2_MEM,
  input  logic [17:0]  tag_L2_MEM,
  input  logic [17:0]  write_tag_L2_MEM,
  input  logic [511:0] write_data_L2_MEM,
  output logic         ready_MEM_L2,
  output logic [511:0] read_data_MEM_L2,
  output logic         busy,
  output logic         proto_err
);

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [3:0]             r_cnt;
  logic                   r_rd;
  logic                   r_wr;
  logic                   r_proto;
  logic [ADDR_BITS-1:0]   r_raddr;
  logic [ADDR_BITS-1:0]   r_waddr;
  logic [511:0]           r_wdata;
  logic [511:0]           r_rdata;
  logic [511:0]           r_mem [DEPTH];
  logic [DEPTH-1:0]       r_valid;

  logic                   w_accept;
  logic                   w_abort;
  logic                   w_enter_resp;
  logic [ADDR_BITS-1:0]   w_raddr_in;
  logic [ADDR_BITS-1:0]   w_waddr_in;
  logic                   w_c_rd;
  logic                   w_c_wr;
  logic [ADDR_BITS-1:0]   w_c_raddr;
  logic [ADDR_BITS-1:0]   w_c_waddr;
  logic [511:0]           w_c_wdata;
  logic [511:0]           w_rdval;

  // Upper tag bits fall away here, so distinct tags may alias onto one line.
  assign w_raddr_in = ADDR_BITS'({tag_L2_MEM, index_L2_MEM});
  assign w_waddr_in = ADDR_BITS'({write_tag_L2_MEM, index_L2_MEM});

  // With LATENCY=1 the response is produced on the accepting edge, so the live inputs stand in for the captured copies.
  assign w_c_rd    = (r_state == S_IDLE) ? read_L2_MEM       : r_rd;
  assign w_c_wr    = (r_state == S_IDLE) ? write_L2_MEM      : r_wr;
  assign w_c_raddr = (r_state == S_IDLE) ? w_raddr_in        : r_raddr;
  assign w_c_waddr = (r_state == S_IDLE) ? w_waddr_in        : r_waddr;
  assign w_c_wdata = (r_state == S_IDLE) ? write_data_L2_MEM : r_wdata;

  always_comb begin
    w_rdval = '0;
    if (w_c_wr && (w_c_waddr == w_c_raddr)) w_rdval = w_c_wdata;
    else if (r_valid[w_c_raddr])            w_rdval = r_mem[w_c_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (read_L2_MEM || write_L2_MEM) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!((r_rd && read_L2_MEM) || (r_wr && write_L2_MEM))) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_enter_resp = 1'b1;
          w_next       = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_proto <= 1'b0;
      r_valid <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= LOAD;
        r_rd  <= read_L2_MEM;
        r_wr  <= write_L2_MEM;
      end else if (w_enter_resp) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && !w_abort) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp && w_c_wr) r_valid[w_c_waddr] <= 1'b1;
      if (w_enter_resp && w_c_rd) r_rdata <= w_rdval;
      if (w_abort)                r_proto <= 1'b1;
    end
  end

  // Storage and captured operands carry no reset; the valid bits decide what is visible.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_raddr <= w_raddr_in;
      r_waddr <= w_waddr_in;
      r_wdata <= write_data_L2_MEM;
    end
    if (w_enter_resp && w_c_wr && !rst) r_mem[w_c_waddr] <= w_c_wdata;
  end

  assign ready_MEM_L2     = (r_state == S_RESP);
  assign busy             = (r_state != S_IDLE);
  assign proto_err        = r_proto;
  assign read_data_MEM_L2 = r_rdata;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized bench for main_mem_responder: a line-array model predicts ready timing,
// busy, returned data and the sticky protocol-error flag.
module tb_main_mem_responder;

  localparam int LAT   = 4;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_L2_MEM;
  logic         write_L2_MEM;
  logic [7:0]   index_L2_MEM;
  logic [17:0]  tag_L2_MEM;
  logic [17:0]  write_tag_L2_MEM;
  logic [511:0] write_data_L2_MEM;
  logic         ready_MEM_L2;
  logic [511:0] read_data_MEM_L2;
  logic         busy;
  logic         proto_err;

  always #5 clk = ~clk;

  main_mem_responder #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk               (clk),
    .rst               (rst),
    .read_L2_MEM       (read_L2_MEM),
    .write_L2_MEM      (write_L2_MEM),
    .index_L2_MEM      (index_L2_MEM),
    .tag_L2_MEM        (tag_L2_MEM),
    .write_tag_L2_MEM  (write_tag_L2_MEM),
    .write_data_L2_MEM (write_data_L2_MEM),
    .ready_MEM_L2      (ready_MEM_L2),
    .read_data_MEM_L2  (read_data_MEM_L2),
    .busy              (busy),
    .proto_err         (proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [511:0] m_mem [DEPTH];
  bit           m_val [DEPTH];
  logic [511:0] m_last;
  bit           m_proto;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int addr_of(input logic [17:0] t, input logic [7:0] i);
    logic [25:0] c;
    c = {t, i};
    return int'(c % 26'(DEPTH));
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) m_val[a] = 1'b0;
    m_last  = '0;
    m_proto = 1'b0;
  endtask

  // Completed transaction: write lands first, then the read sees memory.
  task automatic model_complete(input bit rd, input bit wr, input int ra, input int wa,
                                input logic [511:0] wd);
    if (wr) begin
      m_mem[wa] = wd;
      m_val[wa] = 1'b1;
    end
    if (rd) m_last = m_val[ra] ? m_mem[ra] : '0;
  endtask

  // Called just after a negedge with the DUT idle; abort_at=0 means no abort.
  task automatic do_txn(input bit rd, input bit wr, input logic [17:0] tag,
                        input logic [17:0] wtag, input logic [7:0] idx,
                        input logic [511:0] wd, input int abort_at);
    int ra, wa;
    ra = addr_of(tag, idx);
    wa = addr_of(wtag, idx);
    read_L2_MEM       = rd;
    write_L2_MEM      = wr;
    tag_L2_MEM        = tag;
    write_tag_L2_MEM  = wtag;
    index_L2_MEM      = idx;
    write_data_L2_MEM = wd;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (abort_at != 0 && k > abort_at) begin
        chk("busy_after_abort", 512'(busy), 512'(0));
        chk("ready_after_abort", 512'(ready_MEM_L2), 512'(0));
      end else begin
        chk("busy_wait", 512'(busy), 512'(1));
        chk("ready_timing", 512'(ready_MEM_L2), 512'((k == LAT && abort_at == 0) ? 1 : 0));
      end
      chk("proto_err", 512'(proto_err), 512'(m_proto));
      if (k == LAT && abort_at == 0) model_complete(rd, wr, ra, wa, wd);
      chk("read_data", read_data_MEM_L2, m_last);
      if (k < LAT) begin
        tag_L2_MEM        = 18'($urandom);
        write_tag_L2_MEM  = 18'($urandom);
        index_L2_MEM      = 8'($urandom);
        write_data_L2_MEM = rand_line();
      end
      if (k == abort_at) begin
        read_L2_MEM  = 1'b0;
        write_L2_MEM = 1'b0;
        m_proto      = 1'b1;
      end
      if (k == LAT) begin
        read_L2_MEM  = 1'b0;
        write_L2_MEM = 1'b0;
      end
    end
    @(negedge clk);
    chk("ready_idle", 512'(ready_MEM_L2), 512'(0));
    chk("busy_idle", 512'(busy), 512'(0));
    chk("data_held", read_data_MEM_L2, m_last);
    chk("proto_idle", 512'(proto_err), 512'(m_proto));
  endtask

  // Read held across the response: a second transaction starts right after it.
  task automatic do_b2b(input logic [17:0] tag, input logic [7:0] idx);
    int ra;
    ra = addr_of(tag, idx);
    read_L2_MEM  = 1'b1;
    write_L2_MEM = 1'b0;
    tag_L2_MEM   = tag;
    index_L2_MEM = idx;
    for (int k = 1; k <= 2 * LAT + 1; k++) begin
      @(negedge clk);
      chk("b2b_ready", 512'(ready_MEM_L2), 512'((k == LAT || k == 2 * LAT + 1) ? 1 : 0));
      chk("b2b_busy", 512'(busy), 512'((k == LAT + 1) ? 0 : 1));
      if (k == LAT || k == 2 * LAT + 1) begin
        model_complete(1'b1, 1'b0, ra, 0, '0);
        chk("b2b_data", read_data_MEM_L2, m_last);
      end
    end
    read_L2_MEM = 1'b0;
    @(negedge clk);
    chk("b2b_end_busy", 512'(busy), 512'(0));
  endtask

  task automatic do_reset_mid(input logic [17:0] wtag, input logic [7:0] idx);
    read_L2_MEM       = 1'b0;
    write_L2_MEM      = 1'b1;
    write_tag_L2_MEM  = wtag;
    tag_L2_MEM        = wtag;
    index_L2_MEM      = idx;
    write_data_L2_MEM = rand_line();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("rstmid_busy", 512'(busy), 512'(1));
    end
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    rst          = 1'b0;
    write_L2_MEM = 1'b0;
    chk("rstmid_ready", 512'(ready_MEM_L2), 512'(0));
    chk("rstmid_busy0", 512'(busy), 512'(0));
    chk("rstmid_proto", 512'(proto_err), 512'(0));
    chk("rstmid_data", read_data_MEM_L2, 512'(0));
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("postrst_ready", 512'(ready_MEM_L2), 512'(0));
      chk("postrst_busy", 512'(busy), 512'(0));
    end
  endtask

  initial begin
    logic [511:0] a5;
    for (int w = 0; w < 64; w++) a5[w*8 +: 8] = 8'hA5;

    rst               = 1'b1;
    read_L2_MEM       = 1'b0;
    write_L2_MEM      = 1'b0;
    index_L2_MEM      = '0;
    tag_L2_MEM        = '0;
    write_tag_L2_MEM  = '0;
    write_data_L2_MEM = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 512'(ready_MEM_L2), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_proto", 512'(proto_err), 512'(0));
    chk("rst_data", read_data_MEM_L2, 512'(0));
    rst = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'h05, '0, 0);
    do_txn(1'b0, 1'b1, 18'h0, 18'h00002, 8'h10, a5, 0);
    do_txn(1'b1, 1'b0, 18'h00002, 18'h0, 8'h10, '0, 0);
    do_txn(1'b1, 1'b1, 18'h00003, 18'h00003, 8'h01, 512'h1234, 0);
    do_txn(1'b0, 1'b1, 18'h0, 18'h00004, 8'h00, rand_line(), 0);
    do_txn(1'b1, 1'b0, 18'h00000, 18'h0, 8'h00, '0, 0);
    do_b2b(18'h00002, 8'h10);

    do_txn(1'b1, 1'b0, 18'h00002, 18'h0, 8'h10, '0, 2);
    do_txn(1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, rand_line(), 1);
    do_txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'h05, '0, 0);

    for (int n = 0; n < 40; n++) begin
      bit rd, wr;
      int sel, ab;
      logic [17:0] t, wt;
      logic [7:0]  ix;
      sel = $urandom_range(1, 3);
      rd  = sel[0];
      wr  = sel[1];
      t   = 18'($urandom);
      wt  = ($urandom_range(0, 1) == 1) ? t : 18'($urandom);
      ix  = 8'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT - 1) : 0;
      do_txn(rd, wr, t, wt, ix, rand_line(), ab);
    end

    do_reset_mid(18'h00002, 8'h10);
    do_txn(1'b1, 1'b0, 18'h00002, 18'h0, 8'h10, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to the ready pulse (legal 1..15).
REQ-002 SHALL have parameter ADDR_BITS, default 10, meaning line-address width; storage holds 2^ADDR_BITS lines of 512 bits (legal 8..16).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port read_L2_MEM  in  1  read request level from L2.
REQ-006 SHALL have port write_L2_MEM  in  1  write-back request level from L2.
REQ-007 SHALL have port index_L2_MEM  in  8  line index shared by read and write.
REQ-008 SHALL have port tag_L2_MEM  in  18  read tag.
REQ-009 SHALL have port write_tag_L2_MEM  in  18  write-back tag.
REQ-010 SHALL have port write_data_L2_MEM  in  512  write-back line data.
REQ-011 SHALL have port ready_MEM_L2  out  1  one-cycle completion pulse.
REQ-012 SHALL have port read_data_MEM_L2  out  512  returned line data.
REQ-013 SHALL have port busy  out  1  high while a transaction is outstanding.
REQ-014 SHALL have port proto_err  out  1  sticky protocol-violation flag.

Function
REQ-015 SHALL form read line address as low ADDR_BITS of {tag_L2_MEM, index_L2_MEM} and write line address as low ADDR_BITS of {write_tag_L2_MEM, index_L2_MEM}; higher bits ignored (aliasing permitted).
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL, in IDLE with read or write high at a clock edge, capture request type(s), both line addresses and write data, load counter with LATENCY-1, assert busy, enter WAIT (LATENCY=1: enter RESP directly).
REQ-018 SHALL, in WAIT, decrement counter each cycle and enter RESP when counter reaches 0, so ready_MEM_L2 is high exactly LATENCY cycles after the accepting edge.
REQ-019 SHALL, in RESP, drive ready_MEM_L2=1 for exactly one cycle, then return to IDLE with busy=0.
REQ-020 SHALL commit a captured write to storage at the edge entering RESP and set that line's valid bit.
REQ-021 SHALL register read_data_MEM_L2 at the edge entering RESP with the captured read line; data valid during the ready cycle and held until the next read completes; write-only transactions leave it unchanged.
REQ-022 SHALL return all-zero data for a line whose valid bit is clear.
REQ-023 SHALL treat read and write high together at acceptance as one combined transaction with a single ready pulse: write committed, then read performed; equal addresses return the newly written data.
REQ-024 SHALL ignore changes on address/data inputs after acceptance (captured copies used).
REQ-025 SHALL, if every captured request line drops while in WAIT, abort: no write commit, no ready pulse, return to IDLE, set proto_err.
REQ-026 SHALL accept a new request in the IDLE cycle immediately after RESP (back-to-back, no bubble beyond RESP); request still high in that IDLE cycle is a new transaction.
REQ-027 SHALL keep proto_err set until rst.

Reset
REQ-028 SHALL, on rst high at a clock edge, enter IDLE, clear counter, ready_MEM_L2=0, busy=0, proto_err=0, read_data_MEM_L2=0, and clear all valid bits; storage array contents need not be cleared.
REQ-029 SHALL, on rst during WAIT or RESP, discard the transaction without committing its write; rst has priority over all other events.

Verification
REQ-030 Read of unwritten line: rst, read tag=0x00001 index=0x05 held -> ready high exactly 4 cycles after acceptance, data=0, busy 1 for 4 cycles.
REQ-031 Write then read: write tag=0x00002 index=0x10 data=all 0xA5 until ready, then read same address -> read returns all 0xA5; read_data unchanged during the write transaction.
REQ-032 Combined: read and write both high, write tag=0x00003 index=0x01 data=0x1234 (zero-extended), read same address -> single ready pulse, data=0x1234.
REQ-033 Aliasing: ADDR_BITS=10, write tag=0x00004 index=0x00, read tag=0x00000 index=0x00 -> written data returned.
REQ-034 Abort: read dropped 2 cycles after acceptance -> no ready pulse, proto_err=1 stays 1 across later good transactions until rst.
REQ-035 Reset mid-write: write accepted, rst 2 cycles later, then read same address -> data=0, ready/busy low during and after rst.
